// File: rtl/fill_span_writer.sv
// Fills a horizontal pixel span with a constant colour in a line-organised SRAM.
// Partially covered lines are read, merged and written back; fully covered lines are written blind.
module fill_span_writer #(
    parameter int unsigned ADDR_SIZE_BITS  = 16,
    parameter int unsigned WORD_SIZE_BYTES = 3,
    parameter int unsigned DATA_SIZE_WORDS = 64,
    parameter int unsigned WORDS_PER_ROW   = 10,
    parameter int unsigned LAYER_OFFSET    = 4800
) (
    input  logic                                          clk,
    input  logic                                          n_rst,
    input  logic                                          span_valid,
    output logic                                          span_ready,
    input  logic [9:0]                                    x_start,
    input  logic [9:0]                                    x_end,
    input  logic [8:0]                                    y,
    input  logic [23:0]                                   color_code,
    input  logic                                          layer_num,
    output logic                                          span_done,
    output logic                                          read_enable,
    output logic                                          write_enable,
    output logic [ADDR_SIZE_BITS-1:0]                     address,
    input  logic [WORD_SIZE_BYTES*8*DATA_SIZE_WORDS-1:0]  read_data,
    output logic [WORD_SIZE_BYTES*8*DATA_SIZE_WORDS-1:0]  write_data
);

    localparam int unsigned PixelBits = WORD_SIZE_BYTES * 8;
    localparam int unsigned LineBits  = PixelBits * DATA_SIZE_WORDS;
    localparam int unsigned LastCol   = WORDS_PER_ROW * DATA_SIZE_WORDS - 1;
    localparam int unsigned RowCount  = 480;
    localparam int unsigned IdxBits   = $clog2(WORDS_PER_ROW);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWait,
        StMergeWrite,
        StNext,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [9:0]            x_start_q, x_start_d;
    logic [9:0]            x_end_q, x_end_d;
    logic [8:0]            y_q, y_d;
    logic [23:0]           color_q, color_d;
    logic                  layer_q, layer_d;
    logic [IdxBits-1:0]    w_q, w_d;
    logic [IdxBits-1:0]    w_last_q, w_last_d;
    logic [LineBits-1:0]   line_q, line_d;
    logic                  hold_q, hold_d;

    int unsigned           xs_in;
    int unsigned           xe_in;
    int unsigned           line_base;
    logic [LineBits-1:0]   merged;

    function automatic logic [IdxBits-1:0] line_of(input int unsigned x);
        return IdxBits'(x / DATA_SIZE_WORDS);
    endfunction

    function automatic logic line_full(input logic [IdxBits-1:0] w, input int unsigned xs,
                                       input int unsigned xe);
        int unsigned lo;
        lo = 32'(w) * DATA_SIZE_WORDS;
        return (xs <= lo) && (xe >= lo + DATA_SIZE_WORDS - 1);
    endfunction

    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_q   <= StIdle;
            x_start_q <= '0;
            x_end_q   <= '0;
            y_q       <= '0;
            color_q   <= '0;
            layer_q   <= 1'b0;
            w_q       <= '0;
            w_last_q  <= '0;
            line_q    <= '0;
            hold_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_start_q <= x_start_d;
            x_end_q   <= x_end_d;
            y_q       <= y_d;
            color_q   <= color_d;
            layer_q   <= layer_d;
            w_q       <= w_d;
            w_last_q  <= w_last_d;
            line_q    <= line_d;
            hold_q    <= hold_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        x_start_d    = x_start_q;
        x_end_d      = x_end_q;
        y_d          = y_q;
        color_d      = color_q;
        layer_d      = layer_q;
        w_d          = w_q;
        w_last_d     = w_last_q;
        line_d       = line_q;
        hold_d       = hold_q;
        span_ready   = 1'b0;
        span_done    = 1'b0;
        read_enable  = 1'b0;
        write_enable = 1'b0;
        xs_in        = 32'(x_start);
        xe_in        = (32'(x_end) > LastCol) ? LastCol : 32'(x_end);

        unique case (state_q)
            StIdle: begin
                span_ready = 1'b1;
                if (span_valid) begin
                    x_start_d = x_start;
                    x_end_d   = 10'(xe_in);
                    y_d       = y;
                    color_d   = color_code;
                    layer_d   = layer_num;
                    if (32'(y) >= RowCount || xs_in > xe_in) begin
                        // Empty span: spend one quiet cycle in DONE before pulsing.
                        hold_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        w_d      = line_of(xs_in);
                        w_last_d = line_of(xe_in);
                        state_d  = line_full(line_of(xs_in), xs_in, xe_in) ? StMergeWrite
                                                                           : StRead;
                    end
                end
            end
            StRead: begin
                read_enable = 1'b1;
                state_d     = StWait;
            end
            StWait: begin
                line_d  = read_data;
                state_d = StMergeWrite;
            end
            StMergeWrite: begin
                write_enable = 1'b1;
                state_d      = StNext;
            end
            StNext: begin
                if (w_q == w_last_q) begin
                    state_d = StDone;
                end else begin
                    w_d     = w_q + 1'b1;
                    state_d = line_full(w_q + 1'b1, 32'(x_start_q), 32'(x_end_q)) ? StMergeWrite
                                                                                    : StRead;
                end
            end
            StDone: begin
                if (hold_q) begin
                    hold_d = 1'b0;
                end else begin
                    span_done = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Covered pixels take the fill colour; a full line never reads, so line_q is fully overwritten.
    always_comb begin
        merged    = line_q;
        line_base = 32'(w_q) * DATA_SIZE_WORDS;
        for (int p = 0; p < int'(DATA_SIZE_WORDS); p++) begin
            if (line_base + 32'(p) >= 32'(x_start_q) && line_base + 32'(p) <= 32'(x_end_q)) begin
                merged[p*PixelBits +: PixelBits] = PixelBits'(color_q);
            end
        end
    end

    assign write_data = (state_q == StMergeWrite) ? merged : '0;
    assign address    = ADDR_SIZE_BITS'((layer_q ? LAYER_OFFSET : 32'd0)
                                        + 32'(y_q) * WORDS_PER_ROW + 32'(w_q));

endmodule

// File: doc/fill_span_writer.md
FILL_SPAN_WRITER -- requirements
Module: fill_span_writer

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- ADDR_SIZE_BITS, 16, SRAM word address width.
- WORD_SIZE_BYTES, 3, bytes per pixel.
- DATA_SIZE_WORDS, 64, pixels per SRAM line.
- WORDS_PER_ROW, 10, SRAM lines per 640-pixel row.
- LAYER_OFFSET, 4800, line offset of layer 1.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk, in, 1, the single clock.
- n_rst, in, 1, synchronous, active-high reset (1 = reset).
- span_valid, in, 1, span request.
- span_ready, out, 1, block idle and accepting.
- x_start, in, 10, first pixel column.
- x_end, in, 10, last pixel column, inclusive.
- y, in, 9, row 0..479.
- color_code, in, 24, fill RGB.
- layer_num, in, 1, target layer.
- span_done, out, 1, one-cycle completion pulse.
- read_enable, out, 1, SRAM read strobe.
- write_enable, out, 1, SRAM write strobe.
- address, out, ADDR_SIZE_BITS, SRAM line address.
- read_data, in, 1536, SRAM line read.
- write_data, out, 1536, SRAM line write; pixel p occupies bits [24p+23:24p].
REQ-003 Clocking and reset SHALL be one clock, clk, and n_rst, a synchronous, active-high reset.

Function
REQ-004 The handshake SHALL be: a span is accepted on a rising edge with span_valid=1 and span_ready=1, and all span inputs SHALL be latched at that edge.
REQ-005 span_ready SHALL be 1 only in IDLE, and span_valid SHALL be ignored in every other state.
REQ-006 Clamping SHALL be: x_end>639 is treated as 639, and y>479 makes the span empty.
REQ-007 Empty spans SHALL be handled as follows: if the clamped x_start>x_end or y>479, the block goes IDLE->DONE with no SRAM access.
REQ-008 The states SHALL be IDLE, READ, WAIT, MERGE_WRITE, NEXT, DONE.
REQ-009 Line index SHALL be w = x/64; the first w is x_start/64 and the last w is x_end/64.
REQ-010 Address SHALL be (layer_num ? LAYER_OFFSET : 0) + y*WORDS_PER_ROW + w, truncated to ADDR_SIZE_BITS.
REQ-011 READ SHALL assert read_enable for exactly one cycle with address valid.
REQ-012 WAIT SHALL capture read_data, since SRAM data is valid the cycle after read_enable.
REQ-013 MERGE_WRITE SHALL assert write_enable for one cycle. In write_data, pixels with 64w+p in [max(x_start,64w), min(x_end,64w+63)] SHALL equal color_code, and all other pixels SHALL equal the captured read_data.
REQ-014 Full-line skip SHALL apply: if all 64 pixels of line w are covered, READ/WAIT are skipped, the flow goes NEXT->MERGE_WRITE directly, and no read is issued.
REQ-015 NEXT SHALL go to DONE if w equals the last line. Otherwise it SHALL increment w and go to READ, or to MERGE_WRITE if the new line is full.
REQ-016 DONE SHALL pulse span_done for one cycle and then return to IDLE.
REQ-017 read_enable and write_enable SHALL never be 1 in the same cycle.
REQ-018 address SHALL be held stable during every strobe.
REQ-019 Latency from accept to span_done SHALL be 1+sum over lines (partial: 4, full: 2) cycles, and 2 cycles for an empty span.

Reset
REQ-020 While n_rst=1 at a clock edge, the state SHALL become IDLE and the outputs SHALL be: span_ready=1, span_done=0, read_enable=0, write_enable=0, address=0, write_data=0.
REQ-021 Reset mid-operation SHALL abort the span immediately, with no further strobe on the next cycle and no span_done for the aborted span.
REQ-022 Reset in the same cycle as span_valid SHALL take priority, and the span SHALL not be accepted.

Verification
REQ-023 A bench SHALL cover these scenarios:
- Partial span x=10..20, y=0, layer 0, color 0xFF0000, prefilled line 0 = 0x00FF00 -> one read and one write at address 0; pixels 10..20 = 0xFF0000, all other pixels unchanged; span_done 5 cycles after accept.
- Full span x=0..639, y=2, layer 1 -> 10 writes at addresses 4820..4829, zero reads, span_ready low throughout.
- Cross-line span x=60..70, y=1 -> read/write at address 10 with pixels 60..63 changed, then address 11 with pixels 0..6 changed; span_done 9 cycles after accept.
- Empty span x_start=100, x_end=50, and separately y=500 -> no strobes; span_done 2 cycles after accept.
- n_rst asserted during WAIT of a 3-line span -> next cycle IDLE, no write issued, no span_done; a new span is accepted afterwards normally.
- span_valid held high while busy -> exactly one span accepted; the second is accepted only in the cycle after span_done.
